// File: rtl/fifo_cdc_pkg.sv
// Shared types and constants for the dual-clock FIFO read side.
// FIFO_FWFT_EN selects a first-word-fall-through FIFO (read latency 0).
package fifo_cdc_pkg;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_e;

    localparam int DATA_W_DEF = 8;

`ifdef FIFO_FWFT_EN
    localparam int RD_LAT = 0;
`else
    localparam int RD_LAT = 1;
`endif

    function automatic logic [2:0] occ_cnt(input occ_e o);
        return {1'b0, o};
    endfunction

endpackage

// File: rtl/fifo_rd_stream_if.sv
// Valid/ready stream carrying drained FIFO words downstream.
// master drives valid/data, slave drives ready.
interface fifo_rd_stream_if
    import fifo_cdc_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) ();

    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic              m_ready;

    modport master (output m_valid, output m_data, input m_ready);
    modport slave  (input m_valid, input m_data, output m_ready);

endinterface

// File: rtl/fifo_rd_skid.sv
// Two-entry ordered buffer: head is the registered output word.
// Caller guarantees no push into a full buffer without a pop.
module fifo_rd_skid
    import fifo_cdc_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output occ_e              occ,
    output logic [DATA_W-1:0] head
);

    logic [DATA_W-1:0] tail;
    occ_e              occ_nxt;

    // Occupancy next state: +push -pop, unchanged when both or neither.
    always_comb begin
        occ_nxt = occ;
        unique case (1'b1)
            push && !pop: occ_nxt = (occ == OCC_EMPTY) ? OCC_ONE : OCC_TWO;
            pop && !push: occ_nxt = (occ == OCC_TWO) ? OCC_ONE : OCC_EMPTY;
            default: ;
        endcase
    end

    // Occupancy state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) occ <= OCC_EMPTY;
        else        occ <= occ_nxt;
    end

    // Entry storage; head only moves on pop so it stays stable while held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head <= '0;
            tail <= '0;
        end else begin
            unique case (occ)
                OCC_EMPTY: begin
                    if (push) head <= din;
                end
                OCC_ONE: begin
                    if (push && pop) head <= din;
                    else if (push)   tail <= din;
                end
                OCC_TWO: begin
                    if (pop) begin
                        head <= tail;
                        if (push) tail <= din;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-domain drain controller: FIFO read port to valid/ready stream.
// FIFO_FWFT_EN (via fifo_cdc_pkg::RD_LAT) selects a FWFT FIFO.
module fifo_rd_stream
    import fifo_cdc_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = 16
) (
    input  logic              rd_clk,
    input  logic              rst_n,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_dout,
    output logic              fifo_rd_en,
    fifo_rd_stream_if.master  strm,
    output logic [CNT_W-1:0]  word_cnt,
    output logic              underflow_err
);

    occ_e              occ;
    logic              inflight;
    logic              push;
    logic              pop;
    logic [2:0]        held;
    logic [DATA_W-1:0] head;

    assign pop  = strm.m_valid && strm.m_ready;

    // Words owned after this cycle: buffered plus returning, minus leaving.
    assign held = occ_cnt(occ) + {2'b0, inflight} - {2'b0, pop};

    assign fifo_rd_en = rst_n && !fifo_empty && (held < 3'd2);

    assign strm.m_valid = (occ != OCC_EMPTY);
    assign strm.m_data  = head;

    if (RD_LAT == 0) begin : g_fwft
        assign inflight = 1'b0;
        assign push     = fifo_rd_en;
    end else begin : g_std
        // A read issued this cycle returns fifo_dout on the next one.
        always_ff @(posedge rd_clk or negedge rst_n) begin
            if (!rst_n) inflight <= 1'b0;
            else        inflight <= fifo_rd_en;
        end
        assign push = inflight;
    end

    fifo_rd_skid #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clk   (rd_clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (fifo_dout),
        .occ   (occ),
        .head  (head)
    );

    // Delivered-word counter, wraps naturally.
    always_ff @(posedge rd_clk or negedge rst_n) begin
        if (!rst_n)   word_cnt <= '0;
        else if (pop) word_cnt <= word_cnt + CNT_W'(1);
    end

    // Sticky flag for a read issued against an empty FIFO.
    always_ff @(posedge rd_clk or negedge rst_n) begin
        if (!rst_n)                        underflow_err <= 1'b0;
        else if (fifo_rd_en && fifo_empty) underflow_err <= 1'b1;
    end

endmodule
